// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT unsigned products from the multiplier into
// one ACC_W-bit result and presents it on a valid/ready handshake.
// Tracks carry-out of the accumulator (ovf) and products that arrive while
// a finished sum is still waiting (drop_err, sticky until clear).
// Optional build macro: ACC_SATURATE_EN -- when defined the accumulator
// clamps to all-ones on overflow; otherwise it wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40,
    parameter int COUNT = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  prod_i,
    input  logic             clear_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             ovf_o,
    output logic             drop_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ACC_W-1:0]  sum_q,   sum_d;
    logic              ovf_q,   ovf_d;
    logic              drop_q,  drop_d;

    // Product widened by one bit past the accumulator so the carry is visible.
    logic [ACC_W:0]    prod_ext;
    logic [ACC_W:0]    add_ext;
    logic              add_carry;
    logic [ACC_W-1:0]  add_res;
    logic [CNT_W-1:0]  cnt_inc;

    assign prod_ext  = {{(ACC_W+1-IN_W){1'b0}}, prod_i};
    assign add_ext   = {1'b0, acc_q} + prod_ext;
    assign add_carry = add_ext[ACC_W];
    assign cnt_inc   = cnt_q + CNT_ONE;

    // Accumulate result: wrapping or clamped, depending on build option.
`ifdef ACC_SATURATE_EN
    // Once the batch has overflowed the accumulator stays pinned at all-ones.
    assign add_res = (add_carry || ovf_q) ? ACC_MAX : add_ext[ACC_W-1:0];
`else
    assign add_res = add_ext[ACC_W-1:0];
`endif

    // Next-state and datapath updates; clear has priority over everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (clear_i) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        // First product of a batch: adding to zero cannot carry.
                        acc_d = prod_ext[ACC_W-1:0];
                        cnt_d = CNT_ONE;
                        ovf_d = 1'b0;
                        if (CNT_ONE == CNT_LAST) begin
                            state_d = S_HOLD;
                            sum_d   = prod_ext[ACC_W-1:0];
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    if (valid_i) begin
                        acc_d = add_res;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_carry;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = S_HOLD;
                            sum_d   = add_res;
                        end
                    end
                end

                S_HOLD: begin
                    if (sum_ready_i) begin
                        // Transfer; a coincident product opens the next batch.
                        state_d = S_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        if (valid_i) begin
                            acc_d = prod_ext[ACC_W-1:0];
                            cnt_d = CNT_ONE;
                            if (CNT_ONE == CNT_LAST) begin
                                state_d = S_HOLD;
                                sum_d   = prod_ext[ACC_W-1:0];
                            end else begin
                                state_d = S_ACCUM;
                            end
                        end
                    end else if (valid_i) begin
                        // No slot for this product: discard it and remember.
                        drop_d = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = (state_q == S_HOLD);
    assign ovf_o       = ovf_q;
    assign drop_err_o  = drop_q;

endmodule
